// File: rtl/rs_multi_issue.sv
// rs_multi_issue: reservation station with multi-port CDB wakeup and oldest-ready issue per FU.
// Optional flush port enabled by defining RS_SQUASH_EN.
module rs_multi_issue #(
    parameter int RS_DEPTH   = 16,
    parameter int NUM_FU     = 4,
    parameter int CDB_PORTS  = 2,
    parameter int PHYS_REG_W = 6,
    parameter int OPCODE_W   = 6
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [OPCODE_W-1:0]              opcode_in,
    input  logic [$clog2(NUM_FU)-1:0]        fu_idx,
    input  logic [PHYS_REG_W-1:0]            dest_tag_in,
    input  logic [PHYS_REG_W-1:0]            tag1_in,
    input  logic [PHYS_REG_W-1:0]            tag2_in,
    input  logic                             tag1_rdy_in,
    input  logic                             tag2_rdy_in,
    input  logic [CDB_PORTS-1:0]             cdb_valid,
    input  logic [CDB_PORTS*PHYS_REG_W-1:0]  cdb_tag,
    input  logic [NUM_FU-1:0]                fu_busy,
`ifdef RS_SQUASH_EN
    input  logic                             squash,
`endif
    output logic [NUM_FU-1:0]                issue_valid,
    output logic [NUM_FU*OPCODE_W-1:0]       opcode_out,
    output logic [NUM_FU*PHYS_REG_W-1:0]     dest_tag_out,
    output logic [NUM_FU*PHYS_REG_W-1:0]     tag1_out,
    output logic [NUM_FU*PHYS_REG_W-1:0]     tag2_out,
    output logic                             full,
    output logic [$clog2(RS_DEPTH):0]        free_cnt
);
    localparam int FW = $clog2(NUM_FU);
    localparam int IW = $clog2(RS_DEPTH);
    localparam int CW = $clog2(RS_DEPTH) + 1;

    logic [RS_DEPTH-1:0]   valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [OPCODE_W-1:0]   opcode_q [RS_DEPTH];
    logic [OPCODE_W-1:0]   opcode_d [RS_DEPTH];
    logic [FW-1:0]         fu_q [RS_DEPTH];
    logic [FW-1:0]         fu_d [RS_DEPTH];
    logic [PHYS_REG_W-1:0] dest_q [RS_DEPTH];
    logic [PHYS_REG_W-1:0] dest_d [RS_DEPTH];
    logic [PHYS_REG_W-1:0] tag1_q [RS_DEPTH];
    logic [PHYS_REG_W-1:0] tag1_d [RS_DEPTH];
    logic [PHYS_REG_W-1:0] tag2_q [RS_DEPTH];
    logic [PHYS_REG_W-1:0] tag2_d [RS_DEPTH];
    logic [RS_DEPTH-1:0]   older_q [RS_DEPTH];
    logic [RS_DEPTH-1:0]   older_d [RS_DEPTH];
    logic [RS_DEPTH-1:0]   older_t [RS_DEPTH];
    logic [RS_DEPTH-1:0]   elig [NUM_FU];
    logic [RS_DEPTH-1:0]   hit1, hit2, issued;
    logic                  hin1, hin2, sq, accept;
    logic [IW-1:0]         free_idx;

`ifdef RS_SQUASH_EN
    assign sq = squash;
`else
    assign sq = 1'b0;
`endif

    assign free_cnt = CW'(RS_DEPTH) - CW'($countones(valid_q));
    assign full     = (free_cnt == '0);
    assign accept   = enable && !full && !sq;

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        hin1 = 1'b0;
        hin2 = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p]) begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    hit1[i] = hit1[i] | (cdb_tag[p*PHYS_REG_W +: PHYS_REG_W] == tag1_q[i]);
                    hit2[i] = hit2[i] | (cdb_tag[p*PHYS_REG_W +: PHYS_REG_W] == tag2_q[i]);
                end
                hin1 = hin1 | (cdb_tag[p*PHYS_REG_W +: PHYS_REG_W] == tag1_in);
                hin2 = hin2 | (cdb_tag[p*PHYS_REG_W +: PHYS_REG_W] == tag2_in);
            end
        end
    end

    // older_t[i] lists the entries older than entry i
    always_comb begin
        older_t = '{default: '0};
        elig    = '{default: '0};
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int j = 0; j < RS_DEPTH; j++) older_t[i][j] = older_q[j][i];
            for (int k = 0; k < NUM_FU; k++)
                elig[k][i] = valid_q[i] && rdy1_q[i] && rdy2_q[i] && (fu_q[i] == FW'(k));
        end
    end

    always_comb begin
        issue_valid  = '0;
        opcode_out   = '0;
        dest_tag_out = '0;
        tag1_out     = '0;
        tag2_out     = '0;
        issued       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            issue_valid[k] = (|elig[k]) && !fu_busy[k] && !sq;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (issue_valid[k] && elig[k][i] && !(|(elig[k] & older_t[i]))) begin
                    issued[i] = 1'b1;
                    opcode_out[k*OPCODE_W +: OPCODE_W]     = opcode_q[i];
                    dest_tag_out[k*PHYS_REG_W +: PHYS_REG_W] = dest_q[i];
                    tag1_out[k*PHYS_REG_W +: PHYS_REG_W]     = tag1_q[i];
                    tag2_out[k*PHYS_REG_W +: PHYS_REG_W]     = tag2_q[i];
                end
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) if (!valid_q[i]) free_idx = IW'(i);
        valid_d  = valid_q & ~issued;
        rdy1_d   = rdy1_q | hit1;
        rdy2_d   = rdy2_q | hit2;
        opcode_d = opcode_q;
        fu_d     = fu_q;
        dest_d   = dest_q;
        tag1_d   = tag1_q;
        tag2_d   = tag2_q;
        older_d  = older_q;
        if (accept) begin
            valid_d[free_idx]  = 1'b1;
            rdy1_d[free_idx]   = tag1_rdy_in | hin1;
            rdy2_d[free_idx]   = tag2_rdy_in | hin2;
            opcode_d[free_idx] = opcode_in;
            fu_d[free_idx]     = fu_idx;
            dest_d[free_idx]   = dest_tag_in;
            tag1_d[free_idx]   = tag1_in;
            tag2_d[free_idx]   = tag2_in;
            older_d[free_idx]  = '0;
            for (int i = 0; i < RS_DEPTH; i++) older_d[i][free_idx] = valid_q[i];
        end
        if (sq) valid_d = '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                opcode_q[i] <= '0;
                fu_q[i]     <= '0;
                dest_q[i]   <= '0;
                tag1_q[i]   <= '0;
                tag2_q[i]   <= '0;
                older_q[i]  <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            rdy1_q   <= rdy1_d;
            rdy2_q   <= rdy2_d;
            opcode_q <= opcode_d;
            fu_q     <= fu_d;
            dest_q   <= dest_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
            older_q  <= older_d;
        end
    end
endmodule

// File: tb/tb_rs_multi_issue.sv
// tb_rs_multi_issue: vector table plus issue scoreboard for rs_multi_issue.
module tb_rs_multi_issue;
    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [5:0]  opcode_in, dest_tag_in, tag1_in, tag2_in;
    logic [1:0]  fu_idx;
    logic        tag1_rdy_in, tag2_rdy_in;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [3:0]  fu_busy;
    logic        squash;
    logic [3:0]  issue_valid;
    logic [23:0] opcode_out, dest_tag_out, tag1_out, tag2_out;
    logic        full;
    logic [4:0]  free_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    rs_multi_issue dut (
        .clock(clock), .reset(reset), .enable(enable), .opcode_in(opcode_in), .fu_idx(fu_idx),
        .dest_tag_in(dest_tag_in), .tag1_in(tag1_in), .tag2_in(tag2_in),
        .tag1_rdy_in(tag1_rdy_in), .tag2_rdy_in(tag2_rdy_in), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .fu_busy(fu_busy),
`ifdef RS_SQUASH_EN
        .squash(squash),
`endif
        .issue_valid(issue_valid), .opcode_out(opcode_out), .dest_tag_out(dest_tag_out),
        .tag1_out(tag1_out), .tag2_out(tag2_out), .full(full), .free_cnt(free_cnt)
    );

    typedef struct {
        int en, op, fu, dest, t1, r1, t2, r2, cv, c0, c1, busy, iv, fc;
    } vec_t;

    typedef struct {
        logic [1:0] fu;
        logic [5:0] op, dest, t1, t2;
    } pl_t;

    vec_t tbl [22];
    pl_t  sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int en, op, fu, dest, t1, r1, t2, r2, cv, c0, c1, busy);
        enable      = 1'(en);
        opcode_in   = 6'(op);
        fu_idx      = 2'(fu);
        dest_tag_in = 6'(dest);
        tag1_in     = 6'(t1);
        tag1_rdy_in = 1'(r1);
        tag2_in     = 6'(t2);
        tag2_rdy_in = 1'(r2);
        cdb_valid   = 2'(cv);
        cdb_tag     = {6'(c1), 6'(c0)};
        fu_busy     = 4'(busy);
    endtask

    task automatic push(input int fu, op, dest, t1, t2);
        sb.push_back('{2'(fu), 6'(op), 6'(dest), 6'(t1), 6'(t2)});
    endtask

    task automatic outs(input string n, input int iv, input int fc);
        chk({n, " issue_valid"}, 32'(issue_valid), 32'(iv));
        chk({n, " free_cnt"}, 32'(free_cnt), 32'(fc));
        chk({n, " full"}, 32'(full), 32'(fc == 0));
    endtask

    // each issuing lane must match the oldest outstanding scoreboard entry for that FU
    task automatic observe(input string n);
        for (int k = 0; k < 4; k++) begin
            if (issue_valid[k]) begin
                int idx = -1;
                for (int e = 0; e < sb.size(); e++) if (idx < 0 && sb[e].fu == 2'(k)) idx = e;
                if (idx < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s lane%0d unexpected issue: dest %0d, none expected", n, k, dest_tag_out[k*6 +: 6]);
                end else begin
                    chk($sformatf("%s lane%0d payload", n, k),
                        32'({opcode_out[k*6 +: 6], dest_tag_out[k*6 +: 6], tag1_out[k*6 +: 6], tag2_out[k*6 +: 6]}),
                        32'({sb[idx].op, sb[idx].dest, sb[idx].t1, sb[idx].t2}));
                    sb.delete(idx);
                end
            end else begin
                chk($sformatf("%s lane%0d idle data", n, k),
                    32'({opcode_out[k*6 +: 6], dest_tag_out[k*6 +: 6], tag1_out[k*6 +: 6], tag2_out[k*6 +: 6]}), 32'(0));
            end
        end
    endtask

    initial begin
        //          en op fu dst t1 r1 t2 r2 cv c0 c1 bsy iv fc
        tbl[0]  = '{1, 1, 0, 10, 1, 1, 2, 1, 0, 0, 0, 0, 0, 16};
        tbl[1]  = '{1, 2, 1, 11, 3, 1, 4, 1, 0, 0, 0, 0, 1, 15};
        tbl[2]  = '{1, 3, 2, 12, 5, 1, 7, 0, 0, 0, 0, 0, 2, 15};
        tbl[3]  = '{0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 7, 0, 0, 15};
        tbl[4]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 4, 15};
        tbl[5]  = '{1, 4, 3, 13, 9, 0, 3, 1, 1, 9, 0, 0, 0, 16};
        tbl[6]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 8, 15};
        tbl[7]  = '{1, 5, 0, 20, 1, 1, 2, 1, 0, 0, 0, 0, 0, 16};
        tbl[8]  = '{1, 6, 0, 21, 1, 1, 2, 1, 0, 0, 0, 1, 0, 15};
        tbl[9]  = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 14};
        tbl[10] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 15};
        tbl[11] = '{1, 7, 1, 30, 40, 0, 2, 1, 0, 0, 0, 0, 0, 16};
        tbl[12] = '{1, 8, 2, 31, 40, 0, 2, 1, 0, 0, 0, 0, 0, 15};
        tbl[13] = '{0, 0, 0, 0,  0, 0, 0, 0, 1, 40, 0, 0, 0, 14};
        tbl[14] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 6, 14};
        tbl[15] = '{1, 9, 0, 40, 1, 1, 2, 1, 0, 0, 0, 0, 0, 16};
        tbl[16] = '{1, 10, 0, 41, 50, 0, 2, 1, 0, 0, 0, 0, 1, 15};
        tbl[17] = '{1, 11, 0, 42, 50, 0, 2, 1, 0, 0, 0, 0, 0, 15};
        tbl[18] = '{0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 50, 0, 0, 14};
        tbl[19] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 14};
        tbl[20] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 1, 15};
        tbl[21] = '{0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 16};

        squash = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 outs("reset", 0, 16);
        observe("reset");
        @(negedge clock);
        reset = 1'b1;

        for (int r = 0; r < 22; r++) begin
            @(negedge clock);
            drive(tbl[r].en, tbl[r].op, tbl[r].fu, tbl[r].dest, tbl[r].t1, tbl[r].r1,
                  tbl[r].t2, tbl[r].r2, tbl[r].cv, tbl[r].c0, tbl[r].c1, tbl[r].busy);
            #1;
            outs($sformatf("row%0d", r), tbl[r].iv, tbl[r].fc);
            observe($sformatf("row%0d", r));
            if (tbl[r].en != 0) push(tbl[r].fu, tbl[r].op, tbl[r].dest, tbl[r].t1, tbl[r].t2);
        end

        // fill every entry with an unready src1
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            drive(1, i, 1, i, 20 + i, 0, 2, 1, 0, 0, 0, 0);
            #1 outs($sformatf("fill%0d", i), 0, 16 - i);
            observe($sformatf("fill%0d", i));
            push(1, i, i, 20 + i, 2);
        end
        @(negedge clock);
        drive(1, 63, 1, 63, 20, 0, 2, 1, 0, 0, 0, 0);
        #1 outs("full_ignore", 0, 0);
        observe("full_ignore");
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 0);
        #1 outs("full_wake", 0, 0);
        observe("full_wake");
        @(negedge clock);
        drive(1, 62, 3, 62, 1, 1, 2, 1, 0, 0, 0, 0);
        #1 outs("full_issue", 2, 0);
        observe("full_issue");
        @(negedge clock);
        drive(1, 61, 3, 61, 1, 1, 2, 1, 0, 0, 0, 0);
        #1 outs("slot_free", 0, 1);
        observe("slot_free");
        push(3, 61, 61, 1, 2);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 21, 0);
        #1 outs("refill_issue", 8, 0);
        observe("refill_issue");
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 outs("pre_reset", 2, 1);
        observe("pre_reset");
        #2 reset = 1'b0;
        #1 outs("mid_reset", 0, 16);
        observe("mid_reset");
        sb.delete();
        @(negedge clock);
        reset = 1'b1;

        @(negedge clock);
        drive(1, 33, 2, 50, 1, 1, 2, 1, 0, 0, 0, 0);
        #1 outs("post_reset_disp", 0, 16);
        observe("post_reset_disp");
        push(2, 33, 50, 1, 2);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 outs("post_reset_issue", 4, 15);
        observe("post_reset_issue");

`ifdef RS_SQUASH_EN
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            drive(1, i, i, 44 + i, 1, 1, 2, 1, 0, 0, 0, 15);
            #1 outs($sformatf("sq_fill%0d", i), 0, 16 - i);
        end
        @(negedge clock);
        drive(1, 55, 0, 55, 1, 1, 2, 1, 1, 1, 0, 0);
        squash = 1'b1;
        #1 outs("squash", 0, 12);
        observe("squash");
        @(negedge clock);
        squash = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 outs("post_squash", 0, 16);
        observe("post_squash");
`endif

        chk("scoreboard drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
